// File: rtl/apb_bridge.sv
// rtl/apb_bridge.sv - CPU request to APB bridge with fixed zero-wait slaves
// Decodes a 4 KB window per slave and runs IDLE/SETUP/ACCESS/RESP with registered outputs.
module apb_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          SLV_NUM   = 4,
   parameter int          PADDR_W   = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bus_req,
   input  logic                   bus_we,
   input  logic [31:0]            bus_addr,
   input  logic [31:0]            bus_wdata,
   output logic [31:0]            bus_rdata,
   output logic                   bus_ready,
   output logic                   bus_err,
   output logic [SLV_NUM-1:0]     psel,
   output logic                   penable,
   output logic [PADDR_W-1:0]     paddr,
   output logic                   pwrite,
   output logic [31:0]            pwdata,
   input  logic [SLV_NUM*32-1:0]  prdata_all
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t               state, state_nxt;
   logic [SLV_NUM-1:0]   psel_nxt, sel_dec;
   logic                 penable_nxt, pwrite_nxt, ready_nxt, err_nxt;
   logic [PADDR_W-1:0]   paddr_nxt;
   logic [31:0]          pwdata_nxt, rdata_nxt, rd_mux;
   logic                 hit;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^bus_addr;
   assign hit = (bus_addr[31:16] == BASE_ADDR[31:16]) &&
                ({28'd0, bus_addr[15:12]} < 32'(SLV_NUM));

   always_comb begin
      sel_dec = '0;
      for (int k = 0; k < SLV_NUM; k++)
         sel_dec[k] = (bus_addr[15:12] == 4'(k));
   end

   // The active psel bit doubles as the read-data select, so no slave index is stored.
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < SLV_NUM; k++)
         if (psel[k]) rd_mux = rd_mux | prdata_all[k*32 +: 32];
   end

   always_comb begin
      state_nxt   = state;
      psel_nxt    = '0;
      penable_nxt = 1'b0;
      paddr_nxt   = paddr;
      pwrite_nxt  = pwrite;
      pwdata_nxt  = pwdata;
      rdata_nxt   = bus_rdata;
      ready_nxt   = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (bus_req) begin
               if (hit) begin
                  state_nxt  = SETUP;
                  psel_nxt   = sel_dec;
                  paddr_nxt  = bus_addr[PADDR_W+1:2];
                  pwrite_nxt = bus_we;
                  pwdata_nxt = bus_wdata;
               end else begin
                  state_nxt = RESP;
                  ready_nxt = 1'b1;
                  err_nxt   = 1'b1;
                  rdata_nxt = '0;
               end
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            psel_nxt    = psel;
            penable_nxt = 1'b1;
         end
         ACCESS: begin
            state_nxt = RESP;
            ready_nxt = 1'b1;
            rdata_nxt = pwrite ? 32'd0 : rd_mux;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         psel      <= '0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         bus_rdata <= '0;
         bus_ready <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         psel      <= psel_nxt;
         penable   <= penable_nxt;
         paddr     <= paddr_nxt;
         pwrite    <= pwrite_nxt;
         pwdata    <= pwdata_nxt;
         bus_rdata <= rdata_nxt;
         bus_ready <= ready_nxt;
         bus_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_apb_bridge.sv
// tb/tb_apb_bridge.sv - scoreboard bench for apb_bridge
// Stimulus queues expected SETUP and response events; a negedge monitor pops and compares them.
module tb_apb_bridge;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          bus_req, bus_we;
   logic [31:0]   bus_addr, bus_wdata, bus_rdata;
   logic          bus_ready, bus_err;
   logic [3:0]    psel;
   logic          penable;
   logic [4:0]    paddr;
   logic          pwrite;
   logic [31:0]   pwdata;
   logic [127:0]  prdata_all;

   always #5 clk = ~clk;

   apb_bridge #(.BASE_ADDR(32'h4000_0000), .SLV_NUM(4), .PADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ready(bus_ready), .bus_err(bus_err), .psel(psel), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata_all(prdata_all)
   );

   typedef struct {
      logic [3:0]  psel;
      logic [4:0]  paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      int          cyc;
   } setup_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } resp_t;

   setup_t sq[$];
   resp_t  rq[$];
   setup_t cur;
   resp_t  rsp;
   int     cyc = 0;
   int     errors = 0;
   int     checks = 0;
   bit     mon_en = 1'b0;
   bit     chained = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected or missing (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("psel_onehot0", 32'($onehot0(psel)), 32'd1);
         check("penable_without_psel", 32'(penable && (psel == 4'd0)), 32'd0);
         if (psel != 4'd0 && !penable) begin
            if (sq.size() == 0) fail("unexpected_setup");
            else begin
               cur = sq.pop_front();
               check("setup_psel",   32'(psel),   32'(cur.psel));
               check("setup_paddr",  32'(paddr),  32'(cur.paddr));
               check("setup_pwrite", 32'(pwrite), 32'(cur.pwrite));
               check("setup_pwdata", pwdata,      cur.pwdata);
               check("setup_cycle",  32'(cyc),    32'(cur.cyc));
            end
         end
         if (penable) begin
            check("access_psel",  32'(psel),  32'(cur.psel));
            check("access_paddr", 32'(paddr), 32'(cur.paddr));
         end
         if (bus_ready) begin
            if (rq.size() == 0) fail("unexpected_bus_ready");
            else begin
               rsp = rq.pop_front();
               check("resp_rdata", bus_rdata,     rsp.rdata);
               check("resp_err",   32'(bus_err),  32'(rsp.err));
               check("resp_cycle", 32'(cyc),      32'(rsp.cyc));
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the transfer (or at bus_ready when keep=1).
   task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit hit, input logic [3:0] exp_psel, input logic [4:0] exp_paddr,
                          input logic [31:0] exp_rdata, input bit keep);
      int acc;
      int n;
      acc = chained ? cyc + 2 : cyc + 1;
      if (hit) sq.push_back('{exp_psel, exp_paddr, we, wdata, acc});
      rq.push_back('{exp_rdata, !hit, hit ? acc + 2 : acc});
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      bus_req   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_ready && n < 20);
      if (!bus_ready) fail("bus_ready_timeout");
      chained = keep;
      if (!keep) begin
         bus_req = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      prdata_all = {32'h0BAD_F00D, 32'h1234_5678, 32'hCAFE_0001, 32'h0000_1111};
      rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      repeat (5) @(negedge clk);
      check("rst_psel",      32'(psel),      32'd0);
      check("rst_penable",   32'(penable),   32'd0);
      check("rst_paddr",     32'(paddr),     32'd0);
      check("rst_pwrite",    32'(pwrite),    32'd0);
      check("rst_pwdata",    pwdata,         32'd0);
      check("rst_bus_rdata", bus_rdata,      32'd0);
      check("rst_bus_ready", 32'(bus_ready), 32'd0);
      check("rst_bus_err",   32'(bus_err),   32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      do_xfer(1'b1, 32'h4000_0004, 32'h0000_000A, 1'b1, 4'b0001, 5'h01, 32'h0, 1'b0);
      do_xfer(1'b0, 32'h4000_2018, 32'h0,         1'b1, 4'b0100, 5'h06, 32'h1234_5678, 1'b0);
      do_xfer(1'b0, 32'h5000_0000, 32'h0,         1'b0, 4'b0000, 5'h00, 32'h0, 1'b0);
      do_xfer(1'b0, 32'h4000_7000, 32'h0,         1'b0, 4'b0000, 5'h00, 32'h0, 1'b0);
      do_xfer(1'b0, 32'h4000_0000, 32'h0,         1'b1, 4'b0001, 5'h00, 32'h0000_1111, 1'b0);
      do_xfer(1'b1, 32'h4000_3010, 32'hDEAD_BEEF, 1'b1, 4'b1000, 5'h04, 32'h0, 1'b1);
      do_xfer(1'b0, 32'h4000_107C, 32'h0000_0077, 1'b1, 4'b0010, 5'h1F, 32'hCAFE_0001, 1'b0);

      sq.push_back('{4'b0100, 5'h00, 1'b0, 32'h0, cyc + 1});
      bus_we = 1'b0; bus_addr = 32'h4000_2000; bus_wdata = 32'h0; bus_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_access", 32'(penable), 32'd1);
      rst_n = 1'b0; bus_req = 1'b0;
      @(negedge clk);
      check("abort_psel",    32'(psel),      32'd0);
      check("abort_penable", 32'(penable),   32'd0);
      check("abort_ready",   32'(bus_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chained = 1'b0;
      do_xfer(1'b1, 32'h4000_1008, 32'h0000_55AA, 1'b1, 4'b0010, 5'h02, 32'h0, 1'b0);

      repeat (2) @(negedge clk);
      check("setup_queue_drained", 32'(sq.size()), 32'd0);
      check("resp_queue_drained",  32'(rq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
